// File: rtl/osc_wave_shaper_pkg.sv
// Shared types and constants for the oscillator wave shaper.
// OSC_WAVE_GAIN_EN adds a per-slot output level and one extra pipeline stage.
package osc_wave_pkg;

  localparam int VOICES    = 8;
  localparam int V_OSC     = 4;
  localparam int V_WIDTH   = 3;
  localparam int O_WIDTH   = 2;
  localparam int SLOTS     = VOICES * V_OSC;
  localparam int TAG_W     = V_WIDTH + O_WIDTH;
  localparam int SAMPLE_W  = 16;
  localparam int PHASE_W   = 11;
  localparam int LUT_DEPTH = 512;
  localparam int MAG_W     = 15;

  localparam logic [PHASE_W-1:0] PW_RESET = 11'd1024;

`ifdef OSC_WAVE_GAIN_EN
  localparam int         PIPE_LAT    = 5;
  localparam logic [7:0] LEVEL_RESET = 8'd255;
`else
  localparam int         PIPE_LAT    = 4;
`endif

  typedef enum logic [2:0] {
    SINE   = 3'd0,
    SAW    = 3'd1,
    TRI    = 3'd2,
    PULSE  = 3'd3,
    SILENT = 3'd4
  } wave_e;

  // Codes 4..7 all collapse onto SILENT.
  function automatic wave_e decode_wave(input logic [2:0] code);
    return code[2] ? SILENT : wave_e'(code);
  endfunction

  function automatic logic [MAG_W-1:0] sine_mag(input int i);
    real x;
    x = 32767.0 * $sin(3.14159265358979 * (real'(i) + 0.5) / 1024.0);
    return MAG_W'($rtoi(x + 0.5));
  endfunction

endpackage

// File: rtl/osc_wave_shaper_if.sv
// Slot stream into the shaper and tagged sample stream out of it.
interface osc_wave_shaper_if;
  import osc_wave_pkg::*;

  logic [PHASE_W-1:0]  phase_acc;
  logic [V_WIDTH-1:0]  vx;
  logic [O_WIDTH-1:0]  ox;
  logic                in_valid;
  logic [SAMPLE_W-1:0] sample;
  logic [V_WIDTH-1:0]  out_vx;
  logic [O_WIDTH-1:0]  out_ox;
  logic                out_valid;

  modport master (
    output phase_acc, vx, ox, in_valid,
    input  sample, out_vx, out_ox, out_valid
  );

  modport slave (
    input  phase_acc, vx, ox, in_valid,
    output sample, out_vx, out_ox, out_valid
  );
endinterface

// File: rtl/osc_wave_shaper_qrom.sv
// Synchronous 512x15 quarter-sine ROM; table is built at elaboration.
import osc_wave_pkg::*;

module osc_sine_qrom (
  input  logic                         sCLK_XVXOSC,
  input  logic [$clog2(LUT_DEPTH)-1:0] addr,
  output logic [MAG_W-1:0]             mag
);

  logic [MAG_W-1:0] rom [LUT_DEPTH];

  for (genvar i = 0; i < LUT_DEPTH; i++) begin : g_rom
    localparam logic [MAG_W-1:0] MAG = sine_mag(i);
    assign rom[i] = MAG;
  end

  always_ff @(posedge sCLK_XVXOSC) begin
    mag <= rom[addr];
  end

endmodule

// File: rtl/osc_wave_shaper.sv
// Per-slot phase-to-waveform shaper: config store plus fixed-latency pipeline.
// OSC_WAVE_GAIN_EN enables cfg_level and the scaling stage S4.
import osc_wave_pkg::*;

module osc_wave_shaper (
  input  logic                 sCLK_XVXOSC,
  input  logic                 reset_reg,
  osc_wave_shaper_if.slave     strm,
  input  logic                 cfg_we,
  input  logic [V_WIDTH-1:0]   cfg_vx,
  input  logic [O_WIDTH-1:0]   cfg_ox,
  input  logic [2:0]           cfg_wave,
  input  logic [PHASE_W-1:0]   cfg_pw
`ifdef OSC_WAVE_GAIN_EN
  ,
  input  logic [7:0]           cfg_level
`endif
);

  wave_e              cfg_wave_q [SLOTS];
  logic [PHASE_W-1:0] cfg_pw_q   [SLOTS];
  logic [TAG_W-1:0]   wr_addr, rd_addr;

  assign wr_addr = {cfg_vx, cfg_ox};
  assign rd_addr = {strm.vx, strm.ox};

`ifdef OSC_WAVE_GAIN_EN
  logic [7:0] cfg_lvl_q [SLOTS];
  logic [7:0] s0_level, s1_level, s2_level, s3_level;
`endif

  // Reads see the pre-write contents, so a same-edge write only affects later slots.
  always_ff @(posedge sCLK_XVXOSC or posedge reset_reg) begin
    if (reset_reg) begin
      for (int i = 0; i < SLOTS; i++) begin
        cfg_wave_q[i] <= SINE;
        cfg_pw_q[i]   <= PW_RESET;
`ifdef OSC_WAVE_GAIN_EN
        cfg_lvl_q[i]  <= LEVEL_RESET;
`endif
      end
    end else if (cfg_we) begin
      cfg_wave_q[wr_addr] <= decode_wave(cfg_wave);
      cfg_pw_q[wr_addr]   <= cfg_pw;
`ifdef OSC_WAVE_GAIN_EN
      cfg_lvl_q[wr_addr]  <= cfg_level;
`endif
    end
  end

  logic               s0_valid, s1_valid, s2_valid, s3_valid;
  logic [TAG_W-1:0]   s0_tag, s1_tag, s2_tag, s3_tag;
  logic [PHASE_W-1:0] s0_phase, s0_pw;
  wave_e              s0_wave, s1_wave;
  logic [8:0]         s1_idx;
  logic               s1_neg, s1_pulse_hi;
  logic [9:0]         s1_tri;
  logic [10:0]        s1_saw;
  logic [SAMPLE_W-1:0] s1_alt, s2_alt, s3_next, s3_sample;
  logic               s2_sine, s2_neg;
  logic [MAG_W-1:0]   s2_mag;

  osc_sine_qrom u_qrom (
    .sCLK_XVXOSC (sCLK_XVXOSC),
    .addr        (s1_idx),
    .mag         (s2_mag)
  );

  // Triangle minus 32768 in 16 bits is the same as flipping the MSB.
  always_comb begin
    s1_alt = '0;
    case (s1_wave)
      SAW:     s1_alt = {s1_saw, 5'b0};
      TRI:     s1_alt = {~s1_tri[9], s1_tri[8:0], 6'b0};
      PULSE:   s1_alt = s1_pulse_hi ? 16'h7FFF : 16'h8000;
      default: s1_alt = '0;
    endcase
  end

  always_comb begin
    s3_next = s2_alt;
    if (s2_sine) s3_next = s2_neg ? -{1'b0, s2_mag} : {1'b0, s2_mag};
    if (!s2_valid) s3_next = '0;
  end

  always_ff @(posedge sCLK_XVXOSC or posedge reset_reg) begin
    if (reset_reg) begin
      s0_valid <= 1'b0; s0_tag <= '0; s0_phase <= '0; s0_pw <= PW_RESET; s0_wave <= SINE;
      s1_valid <= 1'b0; s1_tag <= '0; s1_wave <= SINE; s1_idx <= '0; s1_neg <= 1'b0;
      s1_pulse_hi <= 1'b0; s1_tri <= '0; s1_saw <= '0;
      s2_valid <= 1'b0; s2_tag <= '0; s2_sine <= 1'b0; s2_neg <= 1'b0; s2_alt <= '0;
      s3_valid <= 1'b0; s3_tag <= '0; s3_sample <= '0;
`ifdef OSC_WAVE_GAIN_EN
      s0_level <= LEVEL_RESET; s1_level <= LEVEL_RESET;
      s2_level <= LEVEL_RESET; s3_level <= LEVEL_RESET;
`endif
    end else begin
      s0_valid <= strm.in_valid;
      s0_tag   <= rd_addr;
      s0_phase <= strm.phase_acc;
      s0_wave  <= cfg_wave_q[rd_addr];
      s0_pw    <= cfg_pw_q[rd_addr];

      s1_valid    <= s0_valid;
      s1_tag      <= s0_tag;
      s1_wave     <= s0_wave;
      s1_idx      <= s0_phase[9] ? ~s0_phase[8:0] : s0_phase[8:0];
      s1_neg      <= s0_phase[10];
      s1_pulse_hi <= s0_phase < s0_pw;
      s1_tri      <= s0_phase[10] ? ~s0_phase[9:0] : s0_phase[9:0];
      s1_saw      <= {~s0_phase[10], s0_phase[9:0]};

      s2_valid <= s1_valid;
      s2_tag   <= s1_tag;
      s2_sine  <= (s1_wave == SINE);
      s2_neg   <= s1_neg;
      s2_alt   <= s1_alt;

      s3_valid  <= s2_valid;
      s3_tag    <= s2_tag;
      s3_sample <= s3_next;
`ifdef OSC_WAVE_GAIN_EN
      s0_level <= cfg_lvl_q[rd_addr];
      s1_level <= s0_level;
      s2_level <= s1_level;
      s3_level <= s2_level;
`endif
    end
  end

`ifdef OSC_WAVE_GAIN_EN
  logic signed [24:0] prod;
  assign prod = $signed(s3_sample) * $signed({1'b0, s3_level});

  // Taking bits [23:8] of the signed product is an arithmetic shift, i.e. floor.
  always_ff @(posedge sCLK_XVXOSC or posedge reset_reg) begin
    if (reset_reg) begin
      strm.sample    <= '0;
      strm.out_vx    <= '0;
      strm.out_ox    <= '0;
      strm.out_valid <= 1'b0;
    end else begin
      strm.sample    <= prod[23:8];
      strm.out_vx    <= s3_tag[TAG_W-1:O_WIDTH];
      strm.out_ox    <= s3_tag[O_WIDTH-1:0];
      strm.out_valid <= s3_valid;
    end
  end
`else
  assign strm.sample    = s3_sample;
  assign strm.out_vx    = s3_tag[TAG_W-1:O_WIDTH];
  assign strm.out_ox    = s3_tag[O_WIDTH-1:0];
  assign strm.out_valid = s3_valid;
`endif

endmodule
